// File: rtl/axis_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding one AXI-Stream transmitter.
// A granted port stays locked until its tlast beat is accepted downstream.
module axis_tx_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int CNT_WIDTH = 32,
  parameter int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clock,
  input  logic                           areset,
  input  logic [NUM_PORTS*64-1:0]        saxis_tdata,
  input  logic [NUM_PORTS*8-1:0]         saxis_tkeep,
  input  logic [NUM_PORTS-1:0]           saxis_tuser,
  input  logic [NUM_PORTS-1:0]           saxis_tlast,
  input  logic [NUM_PORTS-1:0]           saxis_tvalid,
  output logic [NUM_PORTS-1:0]           saxis_tready,
  output logic [63:0]                    maxis_tdata,
  output logic [7:0]                     maxis_tkeep,
  output logic                           maxis_tuser,
  output logic                           maxis_tlast,
  output logic                           maxis_tvalid,
  input  logic                           maxis_tready,
  output logic                           grant_valid,
  output logic [GW-1:0]                  grant_port,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] frame_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nx;
  logic [GW-1:0]        ptr;
  logic [GW-1:0]        pick;
  logic                 found;
  logic [GW:0]          sum;
  logic                 done;
  logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];

  // Scan ptr, ptr+1, ... wrapping at NUM_PORTS; sum never exceeds 2N-2.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr} + (GW+1)'(i);
      if (sum >= (GW+1)'(NUM_PORTS))
        sum = sum - (GW+1)'(NUM_PORTS);
      if (!found && saxis_tvalid[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    maxis_tdata  = '0;
    maxis_tkeep  = '0;
    maxis_tuser  = 1'b0;
    maxis_tlast  = 1'b0;
    maxis_tvalid = 1'b0;
    saxis_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_port == GW'(i)) begin
          maxis_tdata     = saxis_tdata[i*64 +: 64];
          maxis_tkeep     = saxis_tkeep[i*8 +: 8];
          maxis_tuser     = saxis_tuser[i];
          maxis_tlast     = saxis_tlast[i];
          maxis_tvalid    = saxis_tvalid[i];
          saxis_tready[i] = maxis_tready;
        end
      end
    end
  end

  assign done        = maxis_tvalid & maxis_tready & maxis_tlast;
  assign grant_valid = (state == BUSY);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (found) state_nx = BUSY;
      BUSY: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (areset) begin
      state      <= IDLE;
      grant_port <= '0;
      ptr        <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found)
        grant_port <= pick;
      if (state == BUSY && done)
        ptr <= (grant_port == GW'(NUM_PORTS-1)) ? '0 : grant_port + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (areset)
        cnt[i] <= '0;
      else if (done && grant_port == GW'(i))
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter with three ports.
// Inputs change #1 after the rising edge; outputs are checked #2 after it.
module tb_axis_tx_arbiter;

  localparam int N  = 3;
  localparam int CW = 32;
  localparam int GW = 2;

  logic              clock = 1'b0;
  logic              areset;
  logic [N*64-1:0]   saxis_tdata;
  logic [N*8-1:0]    saxis_tkeep;
  logic [N-1:0]      saxis_tuser;
  logic [N-1:0]      saxis_tlast;
  logic [N-1:0]      saxis_tvalid;
  logic [N-1:0]      saxis_tready;
  logic [63:0]       maxis_tdata;
  logic [7:0]        maxis_tkeep;
  logic              maxis_tuser;
  logic              maxis_tlast;
  logic              maxis_tvalid;
  logic              maxis_tready;
  logic              grant_valid;
  logic [GW-1:0]     grant_port;
  logic [N*CW-1:0]   frame_count;

  int checks   = 0;
  int failures = 0;

  axis_tx_arbiter #(.NUM_PORTS(N), .CNT_WIDTH(CW)) dut (
    .clock(clock), .areset(areset),
    .saxis_tdata(saxis_tdata), .saxis_tkeep(saxis_tkeep),
    .saxis_tuser(saxis_tuser), .saxis_tlast(saxis_tlast),
    .saxis_tvalid(saxis_tvalid), .saxis_tready(saxis_tready),
    .maxis_tdata(maxis_tdata), .maxis_tkeep(maxis_tkeep),
    .maxis_tuser(maxis_tuser), .maxis_tlast(maxis_tlast),
    .maxis_tvalid(maxis_tvalid), .maxis_tready(maxis_tready),
    .grant_valid(grant_valid), .grant_port(grant_port),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int p, input logic [63:0] d,
                       input logic v, input logic l);
    saxis_tdata[p*64 +: 64] = d;
    saxis_tkeep[p*8 +: 8]   = 8'hff;
    saxis_tvalid[p]         = v;
    saxis_tlast[p]          = l;
  endtask

  function automatic logic [CW-1:0] fc(input int p);
    return frame_count[p*CW +: CW];
  endfunction

  initial begin
    areset       = 1'b1;
    saxis_tdata  = '0;
    saxis_tkeep  = '0;
    saxis_tuser  = '0;
    saxis_tlast  = '0;
    saxis_tvalid = '1;
    maxis_tready = 1'b1;

    // reset held two cycles with every source valid
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      check("rst_mvalid", 64'(maxis_tvalid), 64'd0);
      check("rst_sready", 64'(saxis_tready), 64'd0);
      check("rst_gvalid", 64'(grant_valid), 64'd0);
      check("rst_gport", 64'(grant_port), 64'd0);
      check("rst_fcnt", 64'(frame_count == '0), 64'd1);
    end
    saxis_tvalid = '0;
    areset = 1'b0;

    // two-beat frame on port 0
    tick();
    drive(0, 64'h0706050403020100, 1'b1, 1'b0);
    settle();
    check("p0_bubble_mv", 64'(maxis_tvalid), 64'd0);
    check("p0_bubble_sr", 64'(saxis_tready), 64'd0);
    tick();
    settle();
    check("p0_b0_gv", 64'(grant_valid), 64'd1);
    check("p0_b0_data", maxis_tdata, 64'h0706050403020100);
    check("p0_b0_keep", 64'(maxis_tkeep), 64'hff);
    check("p0_b0_sr", 64'(saxis_tready), 64'b001);
    tick();
    drive(0, 64'h0f0e0d0c0b0a0908, 1'b1, 1'b1);
    settle();
    check("p0_b1_data", maxis_tdata, 64'h0f0e0d0c0b0a0908);
    check("p0_b1_last", 64'(maxis_tlast), 64'd1);
    tick();
    drive(0, 64'h0, 1'b0, 1'b0);
    settle();
    check("p0_end_gv", 64'(grant_valid), 64'd0);
    check("p0_end_cnt", 64'(fc(0)), 64'd1);

    // fairness: reset pointer, then everyone sends 1-beat frames
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int p = 0; p < N; p++)
      drive(p, 64'hA0 + 64'(p), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      settle();
      check("rr_gport", 64'(grant_port), 64'(k % 3));
      check("rr_data", maxis_tdata, 64'hA0 + 64'(k % 3));
      tick();
      settle();
      check("rr_idle", 64'(grant_valid), 64'd0);
    end
    check("rr_cnt0", 64'(fc(0)), 64'd2);
    check("rr_cnt1", 64'(fc(1)), 64'd2);
    check("rr_cnt2", 64'(fc(2)), 64'd2);
    saxis_tvalid = '0;
    saxis_tlast  = '0;

    // lock: port 1 gaps mid-frame while port 0 waits
    drive(1, 64'hB1, 1'b1, 1'b0);
    tick();
    settle();
    check("lk_gport", 64'(grant_port), 64'd1);
    check("lk_b0", maxis_tdata, 64'hB1);
    tick();
    drive(1, 64'hB2, 1'b0, 1'b0);
    drive(0, 64'hC0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("lk_gap_sr0", 64'(saxis_tready[0]), 64'd0);
      check("lk_gap_mv", 64'(maxis_tvalid), 64'd0);
      check("lk_gap_gv", 64'(grant_valid), 64'd1);
      tick();
    end
    drive(1, 64'hB2, 1'b1, 1'b1);
    settle();
    check("lk_last", maxis_tdata, 64'hB2);
    check("lk_last_l", 64'(maxis_tlast), 64'd1);
    tick();
    drive(1, 64'h0, 1'b0, 1'b0);
    settle();
    check("lk_cnt1", 64'(fc(1)), 64'd3);
    check("lk_idle", 64'(grant_valid), 64'd0);
    tick();
    settle();
    check("lk_p0_gport", 64'(grant_port), 64'd0);
    check("lk_p0_data", maxis_tdata, 64'hC0);
    tick();
    drive(0, 64'h0, 1'b0, 1'b0);
    settle();
    check("lk_cnt0", 64'(fc(0)), 64'd3);

    // backpressure on beat 2 of a 3-beat frame from port 2
    drive(2, 64'hD1, 1'b1, 1'b0);
    tick();
    settle();
    check("bp_gport", 64'(grant_port), 64'd2);
    check("bp_b1", maxis_tdata, 64'hD1);
    tick();
    drive(2, 64'hD2, 1'b1, 1'b0);
    maxis_tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("bp_hold_data", maxis_tdata, 64'hD2);
      check("bp_hold_sr", 64'(saxis_tready), 64'd0);
      check("bp_hold_cnt", 64'(fc(2)), 64'd2);
      tick();
    end
    maxis_tready = 1'b1;
    settle();
    check("bp_b2_sr", 64'(saxis_tready), 64'b100);
    tick();
    drive(2, 64'hD3, 1'b1, 1'b1);
    settle();
    check("bp_b3", maxis_tdata, 64'hD3);
    check("bp_b3_cnt", 64'(fc(2)), 64'd2);
    tick();
    drive(2, 64'h0, 1'b0, 1'b0);
    settle();
    check("bp_cnt2", 64'(fc(2)), 64'd3);

    // reset on beat 2 of a port 1 frame
    drive(1, 64'hE1, 1'b1, 1'b0);
    tick();
    tick();
    drive(1, 64'hE2, 1'b1, 1'b0);
    settle();
    check("rm_b2", maxis_tdata, 64'hE2);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    settle();
    check("rm_mv", 64'(maxis_tvalid), 64'd0);
    check("rm_gv", 64'(grant_valid), 64'd0);
    check("rm_gport", 64'(grant_port), 64'd0);
    check("rm_fcnt", 64'(frame_count == '0), 64'd1);
    drive(0, 64'hF0, 1'b1, 1'b1);
    drive(2, 64'hF2, 1'b1, 1'b1);
    tick();
    settle();
    check("rm_ptr0", 64'(grant_port), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_tx_arbiter.md
Name: axis_tx_arbiter

Overview:
Frame-granular round-robin arbiter that shares one axis_to_xgmii transmitter between NUM_PORTS AXI-Stream requesters (e.g. MAC user path, pause-frame generator, loopback).
- Once a port is granted, it is locked until its tlast beat is accepted downstream, so frames are never interleaved.
- Sits directly upstream of axis_to_xgmii on the 64-bit / 8-bit-tkeep / tuser / tlast stream.
- Keeps per-port frame counters for debug.

Parameters:
- NUM_PORTS, 2, number of requesting slave streams (2..8).
- CNT_WIDTH, 32, width of each per-port frame counter.
- GW, $clog2(NUM_PORTS) (min 1), grant index width, derived.

Ports:
- clock  in  1  single clock for all logic
- areset  in  1  synchronous, active-high reset
- saxis_tdata  in  NUM_PORTS*64  port i at bits [64*i+63:64*i]
- saxis_tkeep  in  NUM_PORTS*8  per-port byte enables
- saxis_tuser  in  NUM_PORTS  per-port error flag, forwarded unchanged
- saxis_tlast  in  NUM_PORTS  per-port end of frame
- saxis_tvalid  in  NUM_PORTS  per-port valid
- saxis_tready  out  NUM_PORTS  per-port ready
- maxis_tdata  out  64  to axis_to_xgmii
- maxis_tkeep  out  8  to axis_to_xgmii
- maxis_tuser  out  1  to axis_to_xgmii
- maxis_tlast  out  1  to axis_to_xgmii
- maxis_tvalid  out  1  to axis_to_xgmii
- maxis_tready  in  1  from axis_to_xgmii
- grant_valid  out  1  high while a port is locked (BUSY)
- grant_port  out  GW  currently/last granted port
- frame_count  out  NUM_PORTS*CNT_WIDTH  completed frames per port

Behaviour:
Reset (areset=1 at a clock edge, takes priority over everything):
- state=IDLE, grant_port=0, rr pointer=0 (port 0 highest priority), frame_count all 0.
- Resulting outputs: maxis_tvalid=0, saxis_tready=0, grant_valid=0.

IDLE state:
- All saxis_tready=0; maxis_tvalid=0; maxis_tdata/tkeep/tuser/tlast=0. No data transfers.
- If any saxis_tvalid is set, choose the first asserted port scanning ptr, ptr+1, ... modulo NUM_PORTS.
- Register that port into grant_port; next state BUSY.
- Arbitration costs exactly one bubble cycle per frame, so a k-beat frame occupies at least k+1 cycles.

BUSY state:
- maxis_tdata/tkeep/tuser/tlast/tvalid = saxis_*[grant_port], combinationally.
- saxis_tready[grant_port] = maxis_tready; all other saxis_tready = 0.
- No combinational path from any saxis_tvalid to any saxis_tready.
- Beat accepted = maxis_tvalid & maxis_tready.
- Accepted beat with tlast=1:
  - next state IDLE;
  - ptr = (grant_port+1) mod NUM_PORTS;
  - frame_count[grant_port] += 1, wrapping at 2^CNT_WIDTH.
- Granted source drops tvalid mid-frame: stay BUSY, maxis_tvalid=0, other ports keep waiting (lock holds).
- maxis_tready=0: hold; the source holds its data per AXIS rules; nothing is counted.
- A 1-beat frame (tlast on the first beat) is legal: BUSY lasts 1 cycle if tready=1.
- tuser is passed through only; it never affects arbitration or counting. Frames with tuser=1 are still counted.

grant_valid and grant_port:
- grant_valid = (state==BUSY).
- grant_port holds its last value while in IDLE.

Reset mid-frame:
- Immediately returns to IDLE. The partial frame is truncated downstream (maxis_tvalid drops with no tlast).
- Upstream sources are responsible for flushing.

Test Plan:
- Reset: hold areset 2 cycles with all saxis_tvalid=1 -> maxis_tvalid=0, saxis_tready=0, frame_count=0, grant_port=0 throughout.
- Single frame, port 0: two beats 0x0706050403020100 / 0x0f0e0d0c0b0a0908 (second with tlast), tkeep=0xFF, maxis_tready=1 -> one idle cycle, then both beats appear on consecutive cycles; then grant_valid=0 and frame_count[0]=1.
- Fairness, NUM_PORTS=3: all ports continuously valid with 1-beat frames -> grant sequence 0,1,2,0,1,2; each frame_count=2 after 12 cycles.
- Lock under gaps: port 1 granted, drops tvalid for 3 cycles mid-frame while port 0 is valid -> saxis_tready[0] stays 0 and maxis_tvalid=0 for those cycles; port 0 is granted only after port 1's tlast.
- Backpressure: maxis_tready=0 for 4 cycles on beat 2 of 3 -> maxis_tdata stable, saxis_tready[grant]=0, frame_count unchanged until tlast is accepted.
- Reset mid-frame: assert areset on beat 2 of port 1 -> next cycle state IDLE, maxis_tvalid=0, ptr=0, frame_count all 0.
